// File: rtl/dp_pipe_reg.sv
// Two-entry valid/ready pipeline register (main + skid) with registered in_ready.
// Optional stall counter port enabled by defining DP_PIPE_REG_STALL_CNT_EN.
module dp_pipe_reg #(
  parameter int DATAWIDTH = 8
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [DATAWIDTH-1:0] in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [DATAWIDTH-1:0] out_data,
  input  logic                 out_ready
`ifdef DP_PIPE_REG_STALL_CNT_EN
  ,
  output logic [15:0]          stall_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [DATAWIDTH-1:0] main_p1;
  logic [DATAWIDTH-1:0] skid_p1;
  logic                 vld_p1;
  logic                 rdy_p1;
  logic                 in_fire;
  logic                 out_fire;
  logic                 load_main;
  logic                 load_skid;
  logic                 skid_to_main;

  assign in_fire  = in_valid & rdy_p1;
  assign out_fire = vld_p1 & out_ready;

  // Stage p0 -> p1: state, ready and data registers
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= EMPTY;
      rdy_p1  <= 1'b0;
      main_p1 <= '0;
      skid_p1 <= '0;
    end else begin
      state_q <= state_d;
      rdy_p1  <= (state_d != FULL);
      if (load_main)
        main_p1 <= in_data;
      else if (skid_to_main)
        main_p1 <= skid_p1;
      if (load_skid)
        skid_p1 <= in_data;
    end
  end

  always_comb begin
    state_d      = state_q;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d   = ONE;
          load_main = 1'b1;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          load_main = 1'b1;
        end else if (in_fire) begin
          state_d   = FULL;
          load_skid = 1'b1;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only a drain can happen
        if (out_fire) begin
          state_d      = ONE;
          skid_to_main = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d      = EMPTY;
      load_main    = 1'b0;
      load_skid    = 1'b0;
      skid_to_main = 1'b0;
    end
  end

  always_comb begin
    vld_p1 = (state_q != EMPTY);
  end

  assign out_valid = vld_p1;
  assign out_data  = main_p1;
  assign in_ready  = rdy_p1;

`ifdef DP_PIPE_REG_STALL_CNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge Clk) begin
    if (!Rst || flush)
      stall_cnt <= '0;
    else if (vld_p1 && !out_ready)
      stall_cnt <= sat_inc16(stall_cnt);
  end
`endif

endmodule

// File: tb/tb_dp_pipe_reg.sv
// Scoreboard bench for dp_pipe_reg: stimulus pushes accepted data into a FIFO model,
// a negedge monitor pops and compares on every consumer transfer.
module tb_dp_pipe_reg;
  logic       Clk = 1'b0;
  logic       Rst;
  logic       flush;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
`ifdef DP_PIPE_REG_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb[$];
  logic       exp_rdy = 1'b0;
  logic       exp_zero = 1'b1;
  int         exp_stall = 0;
  logic       started = 1'b0;
  logic       last_fire = 1'b0;

  always #5 Clk = ~Clk;

  dp_pipe_reg #(.DATAWIDTH(8)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready)
`ifdef DP_PIPE_REG_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compares presented output against the model and pops on consumer transfer
  always @(negedge Clk) begin
    if (started) begin
      chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      if (sb.size() != 0)
        chk("out_data", 32'(out_data), 32'(sb[0]));
      else if (exp_zero)
        chk("out_data_rst", 32'(out_data), 32'd0);
`ifdef DP_PIPE_REG_STALL_CNT_EN
      chk("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
`endif
      if (Rst && !flush && out_ready && sb.size() != 0)
        void'(sb.pop_front());
    end
  end

  // One clock of stimulus; the model is a plain 2-deep FIFO updated at the edge
  task automatic step(input logic r, input logic f, input logic iv, input logic [7:0] d,
                      input logic ordy);
    logic fire;
    logic cur_ov;
    Rst       = r;
    flush     = f;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    fire   = r && !f && iv && exp_rdy;
    cur_ov = (sb.size() != 0);
    @(posedge Clk);
    if (!r) begin
      sb.delete();
      exp_rdy   = 1'b0;
      exp_stall = 0;
      exp_zero  = 1'b1;
    end else if (f) begin
      sb.delete();
      exp_rdy   = 1'b1;
      exp_stall = 0;
    end else begin
      if (cur_ov && !ordy && exp_stall < 65535)
        exp_stall++;
      if (fire) begin
        sb.push_back(d);
        exp_zero = 1'b0;
      end
      exp_rdy = (sb.size() < 2);
    end
    last_fire = fire;
    started   = 1'b1;
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic ordy);
    int n;
    n = 0;
    do begin
      step(1'b1, 1'b0, 1'b1, d, ordy);
      n++;
    end while (!last_fire && n < 20);
    if (!last_fire)
      chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++)
      step(1'b1, 1'b0, 1'b0, 8'h00, ordy);
  endtask

  initial begin
    logic       pv;
    logic [7:0] pd;
    logic       r;
    logic       f;

    // Reset for two cycles, then a back-to-back stream
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    send(8'h81, 1'b1);
    send(8'h40, 1'b1);
    send(8'h20, 1'b1);
    idle(3, 1'b1);

    // Backpressure: third item must be held off
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b1, 8'h33, 1'b0);
      chk("bp_no_accept", 32'(last_fire), 32'd0);
      chk("bp_out_stable", 32'(out_data), 32'h11);
    end
    send(8'h33, 1'b1);
    idle(4, 1'b1);

    // Simultaneous accept and drain in ONE
    send(8'h0F, 1'b0);
    send(8'hF0, 1'b1);
    chk("simul_data", 32'(out_data), 32'hF0);
    chk("simul_in_ready", 32'(in_ready), 32'd1);
    idle(3, 1'b1);

    // Flush while FULL discards buffered data and the concurrent input
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    step(1'b1, 1'b1, 1'b1, 8'hCC, 1'b0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    idle(3, 1'b1);

    // Reset in the middle of a FULL buffer
    send(8'h5A, 1'b0);
    send(8'hA5, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_data", 32'(out_data), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    idle(2, 1'b1);

    // Randomised traffic with a producer that holds its offer until accepted
    pv = 1'b0;
    pd = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      if (!pv || last_fire) begin
        pv = ($urandom % 4) != 0;
        pd = 8'($urandom);
      end
      r = ($urandom % 150) != 0;
      f = ($urandom % 40) == 0;
      step(r, f, pv, pd, ($urandom % 3) != 0);
    end
    idle(4, 1'b1);

`ifdef DP_PIPE_REG_STALL_CNT_EN
    step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    send(8'h77, 1'b0);
    idle(5, 1'b0);
    chk("stall_5", 32'(stall_cnt), 32'd5);
    idle(70000, 1'b0);
    chk("stall_sat", 32'(stall_cnt), 32'hFFFF);
    idle(3, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
